bus_arbiter: RTL

Two-initiator arbiter for the serial bus. It grants bus ownership to one initiator at a time and steers the shared address/data mux. It handles split transactions: the split initiator is parked, the bus is lent to the other initiator, and the split initiator gets the bus back with top priority when the target is ready to return data. It sits between the initiators' `init_req`/`init_grant`/`init_split_ack` pins and the target-side split signalling.

---
 rtl/bus_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-initiator bus arbiter with split-transaction support. One initiator
//   owns the bus at a time. A split owner is parked while the bus is lent to
//   the other initiator. When the target is ready it is re-granted ahead of
//   every new request.
//
//   Every output is a register. Grants follow the arbitration state one
//   cycle late, so a request sampled at edge N shows up as a grant after
//   edge N+1, and a release likewise drops the grant after edge N+1.
//
//   Build option: define BUS_ARB_ROUND_ROBIN_EN to alternate tie winners.
//   Without it, initiator 1 always wins a tie.
//
// Ports
//   clk           bus clock, rising edge
//   rst_n         asynchronous active-low reset
//   req1 / req2   level bus requests
//   split_start   split response for the current owner (1-cycle pulse)
//   split_resume  split target returning data (held for the whole return)
//   gnt1 / gnt2   grants
//   split_ack1/2  split acknowledge pulses
//   bus_sel       address/data mux select (0 = init 1, 1 = init 2), held when idle
//   bus_busy      a grant is active
//   split_pending a split owner is parked
//   split_err     a split_start was dropped
module bus_arbiter #(
  parameter logic [15:0] MAX_HOLD = 16'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic split_start,
  input  logic split_resume,
  output logic gnt1,
  output logic gnt2,
  output logic split_ack1,
  output logic split_ack2,
  output logic bus_sel,
  output logic bus_busy,
  output logic split_pending,
  output logic split_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GNT1   = 2'd1;
  localparam logic [1:0] S_GNT2   = 2'd2;
  localparam logic [1:0] S_RESUME = 2'd3;

  // Initiators are encoded as 0 = initiator 1 and 1 = initiator 2 throughout.
  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_last;
  logic        r_pend;
  logic [15:0] r_hold;
  logic        r_ack1_p;
  logic        r_ack2_p;

  logic r_gnt1, r_gnt2, r_ack1, r_ack2, r_sel, r_busy, r_pend_o, r_err;

  logic [1:0]  w_state_next;
  logic        w_owner_next;
  logic        w_last_next;
  logic        w_pend_next;
  logic [15:0] w_hold_next;
  logic        w_ack1;
  logic        w_ack2;
  logic        w_err;
  logic        w_elig1;
  logic        w_elig2;
  logic        w_pick2;
  logic        w_hold_limit;
  logic [15:0] w_hold_inc;

  // The parked split owner may not win ordinary arbitration.
  assign w_elig1 = req1 && !(r_pend && !r_owner);
  assign w_elig2 = req2 && !(r_pend &&  r_owner);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  assign w_pick2 = !r_last;
`else
  assign w_pick2 = 1'b0;
`endif

  assign w_hold_limit = (MAX_HOLD != 16'd0) && (r_hold == MAX_HOLD - 16'd1);
  assign w_hold_inc   = (r_hold == 16'hFFFF) ? r_hold : r_hold + 16'd1;

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_pend_next  = r_pend;
    w_hold_next  = r_hold;
    w_ack1       = 1'b0;
    w_ack2       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_err = split_start;
        if (r_pend && split_resume) begin
          w_state_next = S_RESUME;
          w_last_next  = r_owner;
        end else if ((w_elig1 && w_elig2 && w_pick2) || (w_elig2 && !w_elig1)) begin
          w_state_next = S_GNT2;
          w_last_next  = 1'b1;
          w_hold_next  = 16'd0;
        end else if (w_elig1) begin
          w_state_next = S_GNT1;
          w_last_next  = 1'b0;
          w_hold_next  = 16'd0;
        end
      end
      S_GNT1, S_GNT2: begin
        if (split_start && !r_pend) begin
          // Accepted split wins over a simultaneous request drop.
          w_ack1       = (r_state == S_GNT1);
          w_ack2       = (r_state == S_GNT2);
          w_pend_next  = 1'b1;
          w_owner_next = (r_state == S_GNT2);
          w_state_next = S_IDLE;
        end else begin
          w_err = split_start;
          if (!((r_state == S_GNT1) ? req1 : req2)) begin
            w_state_next = S_IDLE;
          end else if (w_hold_limit) begin
            w_state_next = S_IDLE;
          end else begin
            w_hold_next = w_hold_inc;
          end
        end
      end
      default: begin
        w_err = split_start;
        if (!split_resume) begin
          w_pend_next  = 1'b0;
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_pend   <= 1'b0;
      r_hold   <= 16'd0;
      r_ack1_p <= 1'b0;
      r_ack2_p <= 1'b0;
      r_gnt1   <= 1'b0;
      r_gnt2   <= 1'b0;
      r_ack1   <= 1'b0;
      r_ack2   <= 1'b0;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_pend_o <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_last   <= w_last_next;
      r_pend   <= w_pend_next;
      r_hold   <= w_hold_next;
      r_ack1_p <= w_ack1;
      r_ack2_p <= w_ack2;
      // Output stage: decoded from the current state, so acks, grants and
      // the pending flag all move together one cycle after the decision.
      r_gnt1   <= (r_state == S_GNT1) || ((r_state == S_RESUME) && !r_owner);
      r_gnt2   <= (r_state == S_GNT2) || ((r_state == S_RESUME) &&  r_owner);
      r_busy   <= (r_state != S_IDLE);
      r_ack1   <= r_ack1_p;
      r_ack2   <= r_ack2_p;
      r_pend_o <= r_pend;
      r_err    <= w_err;
      case (r_state)
        S_GNT1:   r_sel <= 1'b0;
        S_GNT2:   r_sel <= 1'b1;
        S_RESUME: r_sel <= r_owner;
        default:  r_sel <= r_sel;
      endcase
    end
  end

  assign gnt1          = r_gnt1;
  assign gnt2          = r_gnt2;
  assign split_ack1    = r_ack1;
  assign split_ack2    = r_ack2;
  assign bus_sel       = r_sel;
  assign bus_busy      = r_busy;
  assign split_pending = r_pend_o;
  assign split_err     = r_err;

endmodule
